// File: rtl/power_load_ctrl.sv
// power_load_ctrl: configurable toggle-load generator. It enables a
// thermometer-coded number of LFSR banks in the OFF, STATIC, PWM or RAMP
// pattern, and reports status on four LEDs.
module power_load_ctrl #(
  parameter  int NUM_BANKS = 8,
  parameter  int LFSR_W    = 16,
  parameter  int RAMP_DIV  = 100000,
  parameter  int HB_BIT    = 26,
  localparam int LW        = $clog2(NUM_BANKS + 1)
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [1:0]           cfg_mode,
  input  logic [LW-1:0]        cfg_level,
  input  logic [7:0]           cfg_duty,
  output logic [NUM_BANKS-1:0] bank_en,
  output logic                 load_sig,
  output logic [3:0]           USER_LED
);

  localparam int DW = $clog2(RAMP_DIV);
  localparam int HW = HB_BIT + 1;

  // Maximal-length tap positions (1-based, 0 = unused) for each width.
  function automatic logic [31:0] taps_of(input int w);
    case (w)
      8:       taps_of = {8'd8,  8'd6,  8'd5,  8'd4};
      9:       taps_of = {8'd9,  8'd5,  8'd0,  8'd0};
      10:      taps_of = {8'd10, 8'd7,  8'd0,  8'd0};
      11:      taps_of = {8'd11, 8'd9,  8'd0,  8'd0};
      12:      taps_of = {8'd12, 8'd6,  8'd4,  8'd1};
      13:      taps_of = {8'd13, 8'd4,  8'd3,  8'd1};
      14:      taps_of = {8'd14, 8'd5,  8'd3,  8'd1};
      15:      taps_of = {8'd15, 8'd14, 8'd0,  8'd0};
      17:      taps_of = {8'd17, 8'd14, 8'd0,  8'd0};
      18:      taps_of = {8'd18, 8'd11, 8'd0,  8'd0};
      19:      taps_of = {8'd19, 8'd6,  8'd2,  8'd1};
      20:      taps_of = {8'd20, 8'd17, 8'd0,  8'd0};
      21:      taps_of = {8'd21, 8'd19, 8'd0,  8'd0};
      22:      taps_of = {8'd22, 8'd21, 8'd0,  8'd0};
      23:      taps_of = {8'd23, 8'd18, 8'd0,  8'd0};
      24:      taps_of = {8'd24, 8'd23, 8'd22, 8'd17};
      25:      taps_of = {8'd25, 8'd22, 8'd0,  8'd0};
      26:      taps_of = {8'd26, 8'd6,  8'd2,  8'd1};
      27:      taps_of = {8'd27, 8'd5,  8'd2,  8'd1};
      28:      taps_of = {8'd28, 8'd25, 8'd0,  8'd0};
      29:      taps_of = {8'd29, 8'd27, 8'd0,  8'd0};
      30:      taps_of = {8'd30, 8'd6,  8'd4,  8'd1};
      31:      taps_of = {8'd31, 8'd28, 8'd0,  8'd0};
      32:      taps_of = {8'd32, 8'd22, 8'd2,  8'd1};
      default: taps_of = {8'd16, 8'd15, 8'd13, 8'd4};
    endcase
  endfunction

  function automatic logic [LFSR_W-1:0] tap_mask(input logic [31:0] t);
    tap_mask = '0;
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < LFSR_W; b++) begin
        if (t[8*k +: 8] == 8'(b + 1)) tap_mask[b] = 1'b1;
      end
    end
  endfunction

  localparam logic [LFSR_W-1:0] TAPS = tap_mask(taps_of(LFSR_W));

  typedef enum logic [2:0] {
    S_IDLE,
    S_STATIC,
    S_PWM,
    S_RAMP_UP,
    S_HOLD
  } state_t;

  state_t               r_state;
  logic [LW-1:0]        r_count;
  logic [LW-1:0]        r_level;
  logic [7:0]           r_duty;
  logic [7:0]           r_pwm_cnt;
  logic [DW-1:0]        r_div;
  logic                 r_ready;
  logic [NUM_BANKS-1:0] r_bank_en;
  logic                 r_load;
  logic [3:0]           r_led;
  logic [HW-1:0]        r_hb;

  logic                 w_accept;
  logic [LW-1:0]        w_level_sat;
  logic [7:0]           w_pwm_next;
  logic [HW-1:0]        w_hb_next;
  logic [NUM_BANKS-1:0] w_therm;
  logic [NUM_BANKS-1:0] w_msb;
  logic                 w_load_next;

  assign w_accept    = cfg_valid & r_ready;
  assign w_level_sat = (cfg_level > LW'(NUM_BANKS)) ? LW'(NUM_BANKS) : cfg_level;
  assign w_pwm_next  = r_pwm_cnt + 8'd1;
  assign w_hb_next   = r_hb + HW'(1);
  assign w_load_next = ^w_msb;

  // Mode FSM: tracks the active bank count; an accept always preempts.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_level   <= '0;
      r_duty    <= '0;
      r_pwm_cnt <= '0;
      r_div     <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_ready   <= ~w_accept;
      r_pwm_cnt <= w_pwm_next;
      if (w_accept) begin
        r_level   <= w_level_sat;
        r_duty    <= cfg_duty;
        r_pwm_cnt <= '0;
        r_div     <= '0;
        case (cfg_mode)
          2'd0: begin
            r_state <= S_IDLE;
            r_count <= '0;
          end
          2'd1: begin
            r_state <= S_STATIC;
            r_count <= w_level_sat;
          end
          2'd2: begin
            // pwm_cnt restarts at 0, so the window is on iff duty > 0
            r_state <= S_PWM;
            r_count <= (cfg_duty != 8'd0) ? w_level_sat : '0;
          end
          default: begin
            r_state <= S_RAMP_UP;
            r_count <= '0;
          end
        endcase
      end else begin
        case (r_state)
          S_IDLE:   r_count <= '0;
          S_STATIC: r_count <= r_level;
          S_PWM:    r_count <= (w_pwm_next < r_duty) ? r_level : '0;
          S_RAMP_UP: begin
            if (r_count >= r_level) begin
              r_state <= S_HOLD;
            end else if (r_div == DW'(RAMP_DIV - 1)) begin
              r_div   <= '0;
              r_count <= r_count + LW'(1);
              if ((r_count + LW'(1)) >= r_level) r_state <= S_HOLD;
            end else begin
              r_div <= r_div + DW'(1);
            end
          end
          S_HOLD:   r_count <= r_count;
          default:  r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Registered outputs: thermometer enables, load signal, heartbeat and LEDs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_bank_en <= '0;
      r_load    <= 1'b0;
      r_led     <= '0;
      r_hb      <= '0;
    end else begin
      r_hb      <= w_hb_next;
      r_bank_en <= w_therm;
      r_load    <= w_load_next;
      r_led     <= {w_load_next, (r_state == S_RAMP_UP), |w_therm, w_hb_next[HB_BIT]};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      localparam logic [LFSR_W-1:0] SEED = {1'b1, {(LFSR_W-1){1'b0}}} | LFSR_W'(gi + 1);
      logic [LFSR_W-1:0] r_lfsr;

      assign w_therm[gi] = (r_count > LW'(gi));
      assign w_msb[gi]   = r_lfsr[LFSR_W-1];

      // Bank LFSR toggles only while its enable is set.
      always_ff @(posedge clk_in) begin
        if (rst) begin
          r_lfsr <= SEED;
        end else if (r_bank_en[gi]) begin
          r_lfsr <= {r_lfsr[LFSR_W-2:0], ^(r_lfsr & TAPS)};
        end
      end
    end
  endgenerate

  assign cfg_ready = r_ready;
  assign bank_en   = r_bank_en;
  assign load_sig  = r_load;
  assign USER_LED  = r_led;

endmodule

// File: doc/power_load_ctrl.md
POWER_LOAD_CTRL -- requirements
Module: power_load_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_BANKS, default 8, meaning the number of independent toggle-load banks (range 1..32).
REQ-002 The block SHALL have parameter LFSR_W, default 16, meaning the width of each bank's LFSR (range 8..32).
REQ-003 The block SHALL have parameter RAMP_DIV, default 100000, meaning clk_in cycles per ramp step (minimum 2).
REQ-004 The block SHALL have parameter HB_BIT, default 26, meaning the free-running counter bit driven to the heartbeat LED.
REQ-005 The block SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port cfg_valid, input, 1 bit: the configuration request.
REQ-008 The block SHALL have port cfg_ready, output, 1 bit: configuration accept.
REQ-009 The block SHALL have port cfg_mode, input, 2 bits: 0 OFF, 1 STATIC, 2 PWM, 3 RAMP.
REQ-010 The block SHALL have port cfg_level, input, $clog2(NUM_BANKS+1) bits: the target number of active banks.
REQ-011 The block SHALL have port cfg_duty, input, 8 bits: the PWM on-cycles per 256-cycle period.
REQ-012 The block SHALL have port bank_en, output, NUM_BANKS bits: the per-bank activity enables.
REQ-013 The block SHALL have port load_sig, output, 1 bit: the XOR-reduction of all LFSR MSBs (keeps the load logic alive).
REQ-014 The block SHALL have port USER_LED, output, 4 bits: the status LEDs.

Function
REQ-015 A configuration SHALL be accepted on any cycle where cfg_valid and cfg_ready are both 1.
REQ-016 cfg_ready SHALL be 1 in every state except the single cycle immediately after an accept.
REQ-017 The accepted mode, level and duty SHALL take effect on the cycle after the accept.
REQ-018 A cfg_level greater than NUM_BANKS SHALL saturate to NUM_BANKS.
REQ-019 The FSM SHALL have the states IDLE, STATIC, PWM, RAMP_UP and HOLD.
REQ-020 On accept, mode 0 SHALL go to IDLE, 1 to STATIC, 2 to PWM, and 3 to RAMP_UP.
REQ-021 On a mode-3 accept, the active count SHALL reset to 0.
REQ-022 A new accept SHALL preempt any state, including a ramp in progress.
REQ-023 The active count SHALL be 0 in IDLE.
REQ-024 The active count SHALL equal the level in STATIC.
REQ-025 In PWM, the active count SHALL equal the level while pwm_cnt < duty, and 0 otherwise.
REQ-026 pwm_cnt SHALL be an 8-bit free-running counter that wraps 255->0 and is cleared on every accept.
REQ-027 A duty of 0 SHALL keep the banks always off in PWM.
REQ-028 A duty of 255 SHALL turn the banks off for 1 of every 256 cycles.
REQ-029 In RAMP_UP, a RAMP_DIV-cycle divider SHALL increment the active count by 1 each time it expires.
REQ-030 When the active count reaches the level, the FSM SHALL go to HOLD.
REQ-031 A ramp with level 0 SHALL go directly to HOLD on the next cycle.
REQ-032 HOLD SHALL keep the active count constant until the next accept.
REQ-033 bank_en SHALL be a registered thermometer code in which bit i = 1 iff i < the active count.
REQ-034 bank_en SHALL lag the active-count state by 1 cycle.
REQ-035 Each bank SHALL own a maximal-length Fibonacci LFSR, seeded to a distinct nonzero value per bank (bank index + 1 in the LSBs, MSB set).
REQ-036 A bank's LFSR SHALL advance only while its bank_en bit is 1, and hold otherwise.
REQ-037 load_sig SHALL be registered, the XOR of all LFSR MSBs, with 1-cycle latency.
REQ-038 USER_LED[0] SHALL be bit HB_BIT of a free-running counter of width HB_BIT+1.
REQ-039 USER_LED[1] SHALL be the OR of bank_en.
REQ-040 USER_LED[2] SHALL be 1 iff the state is RAMP_UP.
REQ-041 USER_LED[3] SHALL be load_sig.
REQ-042 All outputs SHALL be registered.

Reset
REQ-043 While rst = 1, the FSM SHALL be IDLE, the active count 0, bank_en 0, and pwm_cnt, the ramp divider and the heartbeat counter 0.
REQ-044 While rst = 1, the LFSRs SHALL be loaded with their seeds, load_sig = 0, USER_LED = 0 and cfg_ready = 0.
REQ-045 cfg_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-046 rst asserted mid-ramp or mid-PWM SHALL abort on the next edge, with no residual bank_en.

Verification
REQ-047 Scenario: NUM_BANKS=8, accept mode 1 with level 5 -> bank_en = 8'h1F two cycles after the accept and stable thereafter; LFSRs 0..4 advance and 5..7 hold.
REQ-048 Scenario: accept mode 1 with level 12 (NUM_BANKS=8) -> bank_en = 8'hFF, saturated.
REQ-049 Scenario: accept mode 2 with level 8 and duty 64 -> bank_en = 8'hFF for exactly 64 of every 256 cycles, the first on-window starting 2 cycles after the accept; duty 0 -> always 0.
REQ-050 Scenario: RAMP_DIV=4, accept mode 3 with level 3 -> bank_en steps 0x0 -> 0x1 -> 0x3 -> 0x7 at 4-cycle intervals, then HOLD, with USER_LED[2] falling when the count reaches 3.
REQ-051 Scenario: mid-ramp accept of mode 0 -> bank_en = 0 two cycles later and the state is IDLE; back-to-back cfg_valid -> the second request is accepted one cycle after the first (cfg_ready low for 1 cycle).
REQ-052 Scenario: rst pulsed during PWM with duty 128 -> on the next edge bank_en = 0, USER_LED = 0 and the LFSRs are reseeded; the heartbeat toggles every 2^HB_BIT cycles afterwards (checked with HB_BIT=3).
